// File: rtl/fs_pkg.sv
// Shared constants, state encoding and board-addressing helper for the
// five-in-a-row game controller and its line scanner.
package fs_pkg;

    localparam int BOARD_N     = 16;
    localparam int DEF_START_X = 4;
    localparam int DEF_START_Y = 6;
    localparam int DEF_WIN_LEN = 5;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] ST_PLAYING = 2'b00;
    localparam logic [1:0] ST_P1WIN   = 2'b01;
    localparam logic [1:0] ST_P2WIN   = 2'b10;
    localparam logic [1:0] ST_DRAW    = 2'b11;

    // Scan directions in order: horizontal, vertical, diagonal, anti-diagonal.
    localparam logic signed [1:0] DIR_DX [0:3] = '{2'sd1, 2'sd0, 2'sd1, 2'sd1};
    localparam logic signed [1:0] DIR_DY [0:3] = '{2'sd0, 2'sd1, 2'sd1, -2'sd1};

    typedef enum logic [1:0] {
        GS_WAIT = 2'd0,
        GS_SCAN = 2'd1,
        GS_OVER = 2'd2
    } state_t;

    function automatic logic [8:0] co_to_offset(input logic [3:0] x, input logic [3:0] y);
        return ({5'd0, x} * 9'd2) + ({5'd0, y} * 9'd32);
    endfunction

endpackage

// File: rtl/fs_line_scanner.sv
// Walks outward from the last stone in four directions, one cell per cycle,
// and reports done (with win) once a run of WIN_LEN is found or all directions fail.
module fs_line_scanner
    import fs_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       srst,
    input  logic       start,
    input  logic [3:0] px,
    input  logic [3:0] py,
    input  logic [1:0] colour,
    output logic       rd_req,
    output logic [3:0] rd_x,
    output logic [3:0] rd_y,
    input  logic [1:0] rd_data,
    output logic       done,
    output logic       win
);

    logic             active_r;
    logic [1:0]       dir_r;
    logic             neg_r;
    logic [2:0]       k_r;
    logic [2:0]       cnt_r;
    logic [3:0]       px_r;
    logic [3:0]       py_r;
    logic [1:0]       colour_r;
    logic             done_r;
    logic             win_r;

    logic signed [4:0] off_x_s;
    logic signed [4:0] off_y_s;
    logic signed [4:0] cx_s;
    logic signed [4:0] cy_s;
    logic              in_range_s;
    logic              match_s;

    function automatic logic signed [4:0] scale_step(input logic signed [1:0] d,
                                                     input logic [2:0] k);
        logic signed [4:0] kk;
        kk = $signed({2'b00, k});
        if (d == 2'sd1) begin
            return kk;
        end else if (d == -2'sd1) begin
            return -kk;
        end else begin
            return 5'sd0;
        end
    endfunction

    // Address of the cell under examination; negative or >15 falls out of range.
    always_comb begin
        off_x_s = scale_step(DIR_DX[dir_r], k_r);
        off_y_s = scale_step(DIR_DY[dir_r], k_r);
        if (neg_r) begin
            off_x_s = -off_x_s;
            off_y_s = -off_y_s;
        end else begin
            off_x_s = off_x_s;
            off_y_s = off_y_s;
        end
        cx_s       = $signed({1'b0, px_r}) + off_x_s;
        cy_s       = $signed({1'b0, py_r}) + off_y_s;
        in_range_s = !cx_s[4] && !cy_s[4];
        rd_req     = active_r && in_range_s;
        rd_x       = cx_s[3:0];
        rd_y       = cy_s[3:0];
        match_s    = rd_req && (rd_data == colour_r);
    end

    // Walker state: direction, sense, distance and run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_r <= 1'b0;
            dir_r    <= 2'd0;
            neg_r    <= 1'b0;
            k_r      <= 3'd1;
            cnt_r    <= 3'd1;
            px_r     <= 4'd0;
            py_r     <= 4'd0;
            colour_r <= CELL_EMPTY;
            done_r   <= 1'b0;
            win_r    <= 1'b0;
        end else if (srst) begin
            active_r <= 1'b0;
            dir_r    <= 2'd0;
            neg_r    <= 1'b0;
            k_r      <= 3'd1;
            cnt_r    <= 3'd1;
            px_r     <= 4'd0;
            py_r     <= 4'd0;
            colour_r <= CELL_EMPTY;
            done_r   <= 1'b0;
            win_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            win_r  <= 1'b0;
            if (start) begin
                active_r <= 1'b1;
                dir_r    <= 2'd0;
                neg_r    <= 1'b0;
                k_r      <= 3'd1;
                cnt_r    <= 3'd1;
                px_r     <= px;
                py_r     <= py;
                colour_r <= colour;
            end else if (active_r) begin
                if (match_s) begin
                    if (cnt_r + 3'd1 == 3'(WIN_LEN)) begin
                        active_r <= 1'b0;
                        done_r   <= 1'b1;
                        win_r    <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                        k_r   <= k_r + 3'd1;
                    end
                end else if (!neg_r) begin
                    neg_r <= 1'b1;
                    k_r   <= 3'd1;
                end else if (dir_r == 2'd3) begin
                    active_r <= 1'b0;
                    done_r   <= 1'b1;
                end else begin
                    dir_r <= dir_r + 2'd1;
                    neg_r <= 1'b0;
                    k_r   <= 3'd1;
                    cnt_r <= 3'd1;
                end
            end else begin
                active_r <= 1'b0;
            end
        end
    end

    assign done = done_r;
    assign win  = win_r;

endmodule

// File: rtl/fs_game_ctrl.sv
// Five-in-a-row game sequencer: owns the board, cursor, turn and game status,
// places stones on key pulses and launches a line scan after every placement.
module fs_game_ctrl
    import fs_pkg::*;
#(
    parameter int N       = BOARD_N,
    parameter int START_X = DEF_START_X,
    parameter int START_Y = DEF_START_Y,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input  logic         Clck,
    input  logic         Reset,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_place,
    input  logic         restart,
    output logic [511:0] board,
    output logic [1:0]   gaming_status,
    output logic [3:0]   pointer_loc_x,
    output logic [3:0]   pointer_loc_y,
    output logic [1:0]   cur_player,
    output logic         busy,
    output logic         place_reject
);

    state_t       state_r;
    logic [511:0] board_r;
    logic [1:0]   status_r;
    logic [3:0]   ptr_x_r;
    logic [3:0]   ptr_y_r;
    logic [1:0]   player_r;
    logic         busy_r;
    logic         reject_r;
    logic [8:0]   move_cnt_r;

    logic [3:0]   nx_s;
    logic [3:0]   ny_s;
    logic [8:0]   cur_off_s;
    logic [1:0]   cur_cell_s;
    logic         start_s;
    logic         rd_req_s;
    logic [3:0]   rd_x_s;
    logic [3:0]   rd_y_s;
    logic [1:0]   rd_data_s;
    logic         scan_done_s;
    logic         scan_win_s;

    // Clamped cursor step; opposing pulses on one axis cancel.
    always_comb begin
        nx_s = ptr_x_r;
        ny_s = ptr_y_r;
        if (btn_right && !btn_left) begin
            if (ptr_x_r != 4'(N - 1)) nx_s = ptr_x_r + 4'd1;
            else                      nx_s = ptr_x_r;
        end else if (btn_left && !btn_right) begin
            if (ptr_x_r != 4'd0) nx_s = ptr_x_r - 4'd1;
            else                 nx_s = ptr_x_r;
        end else begin
            nx_s = ptr_x_r;
        end
        if (btn_down && !btn_up) begin
            if (ptr_y_r != 4'(N - 1)) ny_s = ptr_y_r + 4'd1;
            else                      ny_s = ptr_y_r;
        end else if (btn_up && !btn_down) begin
            if (ptr_y_r != 4'd0) ny_s = ptr_y_r - 4'd1;
            else                 ny_s = ptr_y_r;
        end else begin
            ny_s = ptr_y_r;
        end
    end

    // Board read ports for the cursor cell and the scanner's requested cell.
    always_comb begin
        cur_off_s  = co_to_offset(ptr_x_r, ptr_y_r);
        cur_cell_s = board_r[cur_off_s +: 2];
        if (rd_req_s) begin
            rd_data_s = board_r[co_to_offset(rd_x_s, rd_y_s) +: 2];
        end else begin
            rd_data_s = CELL_EMPTY;
        end
        start_s = (state_r == GS_WAIT) && btn_place && (cur_cell_s == CELL_EMPTY) && !restart;
    end

    fs_line_scanner #(
        .WIN_LEN (WIN_LEN)
    ) u_scanner (
        .clk     (Clck),
        .rst     (Reset),
        .srst    (restart),
        .start   (start_s),
        .px      (ptr_x_r),
        .py      (ptr_y_r),
        .colour  (player_r),
        .rd_req  (rd_req_s),
        .rd_x    (rd_x_s),
        .rd_y    (rd_y_s),
        .rd_data (rd_data_s),
        .done    (scan_done_s),
        .win     (scan_win_s)
    );

    // Game FSM with all externally visible state registered here.
    always_ff @(posedge Clck or posedge Reset) begin
        if (Reset) begin
            state_r    <= GS_WAIT;
            board_r    <= 512'd0;
            status_r   <= ST_PLAYING;
            ptr_x_r    <= 4'(START_X);
            ptr_y_r    <= 4'(START_Y);
            player_r   <= CELL_P1;
            busy_r     <= 1'b0;
            reject_r   <= 1'b0;
            move_cnt_r <= 9'd0;
        end else if (restart) begin
            state_r    <= GS_WAIT;
            board_r    <= 512'd0;
            status_r   <= ST_PLAYING;
            ptr_x_r    <= 4'(START_X);
            ptr_y_r    <= 4'(START_Y);
            player_r   <= CELL_P1;
            busy_r     <= 1'b0;
            reject_r   <= 1'b0;
            move_cnt_r <= 9'd0;
        end else begin
            reject_r <= 1'b0;
            case (state_r)
                GS_WAIT: begin
                    if (btn_place) begin
                        if (cur_cell_s == CELL_EMPTY) begin
                            board_r[cur_off_s +: 2] <= player_r;
                            move_cnt_r <= move_cnt_r + 9'd1;
                            busy_r     <= 1'b1;
                            state_r    <= GS_SCAN;
                        end else begin
                            reject_r <= 1'b1;
                        end
                    end else begin
                        ptr_x_r <= nx_s;
                        ptr_y_r <= ny_s;
                    end
                end
                GS_SCAN: begin
                    if (scan_done_s) begin
                        busy_r <= 1'b0;
                        if (scan_win_s) begin
                            status_r <= (player_r == CELL_P1) ? ST_P1WIN : ST_P2WIN;
                            state_r  <= GS_OVER;
                        end else if (move_cnt_r == 9'd256) begin
                            status_r <= ST_DRAW;
                            state_r  <= GS_OVER;
                        end else begin
                            player_r <= (player_r == CELL_P1) ? CELL_P2 : CELL_P1;
                            state_r  <= GS_WAIT;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                GS_OVER: begin
                    ptr_x_r  <= nx_s;
                    ptr_y_r  <= ny_s;
                    reject_r <= btn_place;
                end
                default: begin
                    state_r <= GS_WAIT;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign board         = board_r;
    assign gaming_status = status_r;
    assign pointer_loc_x = ptr_x_r;
    assign pointer_loc_y = ptr_y_r;
    assign cur_player    = player_r;
    assign busy          = busy_r;
    assign place_reject  = reject_r;

endmodule

// File: tb/tb_fs_game_ctrl.sv
// Directed plus randomized bench for fs_game_ctrl against a board-level game model.
module tb_fs_game_ctrl;

    logic         Clck = 1'b0;
    logic         Reset;
    logic         btn_up, btn_down, btn_left, btn_right, btn_place, restart;
    logic [511:0] board;
    logic [1:0]   gaming_status;
    logic [3:0]   pointer_loc_x, pointer_loc_y;
    logic [1:0]   cur_player;
    logic         busy, place_reject;

    always #5 Clck = ~Clck;

    fs_game_ctrl dut (
        .Clck(Clck), .Reset(Reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_place(btn_place), .restart(restart),
        .board(board), .gaming_status(gaming_status),
        .pointer_loc_x(pointer_loc_x), .pointer_loc_y(pointer_loc_y),
        .cur_player(cur_player), .busy(busy), .place_reject(place_reject)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference game: board as a grid, cursor, mover, status, move count.
    logic [1:0] mb [16][16];
    int         mx, my, mmoves;
    logic [1:0] mplayer, mstatus;
    bit         mover;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                mb[x][y] = 2'b00;
        mx = 4; my = 6; mmoves = 0; mplayer = 2'b01; mstatus = 2'b00; mover = 1'b0;
    endtask

    function automatic logic [511:0] model_vec();
        logic [511:0] v;
        v = '0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                v[x*2 + y*32 +: 2] = mb[x][y];
        return v;
    endfunction

    function automatic int run_len(int x, int y, int dx, int dy, logic [1:0] c);
        int n = 0;
        int cx = x + dx;
        int cy = y + dy;
        while (cx >= 0 && cx < 16 && cy >= 0 && cy < 16 && mb[cx][cy] == c) begin
            n++; cx += dx; cy += dy;
        end
        return n;
    endfunction

    // A line through (x,y) of at least five stones of colour c wins.
    function automatic bit wins_at(int x, int y, logic [1:0] c);
        bit w = 1'b0;
        if (1 + run_len(x, y, 1, 0, c) + run_len(x, y, -1, 0, c) >= 5) w = 1'b1;
        if (1 + run_len(x, y, 0, 1, c) + run_len(x, y, 0, -1, c) >= 5) w = 1'b1;
        if (1 + run_len(x, y, 1, 1, c) + run_len(x, y, -1, -1, c) >= 5) w = 1'b1;
        if (1 + run_len(x, y, 1, -1, c) + run_len(x, y, -1, 1, c) >= 5) w = 1'b1;
        return w;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".board"},  board,         model_vec());
        check({tag, ".status"}, gaming_status, mstatus);
        check({tag, ".player"}, cur_player,    mplayer);
        check({tag, ".x"},      pointer_loc_x, mx);
        check({tag, ".y"},      pointer_loc_y, my);
        check({tag, ".busy"},   busy,          1'b0);
        check({tag, ".reject"}, place_reject,  1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".board"},  board,         512'd0);
        check({tag, ".status"}, gaming_status, 2'b00);
        check({tag, ".x"},      pointer_loc_x, 4'd4);
        check({tag, ".y"},      pointer_loc_y, 4'd6);
        check({tag, ".player"}, cur_player,    2'b01);
        check({tag, ".busy"},   busy,          1'b0);
        check({tag, ".reject"}, place_reject,  1'b0);
    endtask

    task automatic do_move(input bit u, input bit d, input bit l, input bit r);
        @(negedge Clck);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        @(negedge Clck);
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        if (r && !l)      mx = (mx < 15) ? mx + 1 : mx;
        else if (l && !r) mx = (mx > 0)  ? mx - 1 : mx;
        if (d && !u)      my = (my < 15) ? my + 1 : my;
        else if (u && !d) my = (my > 0)  ? my - 1 : my;
        check("move.x", pointer_loc_x, mx);
        check("move.y", pointer_loc_y, my);
    endtask

    task automatic goto(input int x, input int y);
        while (mx != x) do_move(1'b0, 1'b0, mx > x, mx < x);
        while (my != y) do_move(my > y, my < y, 1'b0, 1'b0);
    endtask

    task automatic do_place();
        bit accept;
        int cycles;
        accept = !mover && (mb[mx][my] == 2'b00);
        @(negedge Clck);
        btn_place = 1'b1;
        @(negedge Clck);
        btn_place = 1'b0;
        if (!accept) begin
            check("reject.pulse", place_reject, 1'b1);
            check("reject.busy",  busy,         1'b0);
            @(negedge Clck);
            check("reject.drop",  place_reject, 1'b0);
        end else begin
            mb[mx][my] = mplayer;
            mmoves++;
            check("place.busy_rise", busy, 1'b1);
            cycles = 0;
            while (busy === 1'b1 && cycles < 60) begin
                @(negedge Clck);
                cycles++;
            end
            check("place.scan_bound", cycles <= 40, 1'b1);
            if (wins_at(mx, my, mplayer)) begin
                mstatus = mplayer; mover = 1'b1;
            end else if (mmoves == 256) begin
                mstatus = 2'b11; mover = 1'b1;
            end else begin
                mplayer = (mplayer == 2'b01) ? 2'b10 : 2'b01;
            end
        end
        check_state("place");
    endtask

    task automatic place_at(input int x, input int y);
        goto(x, y);
        do_place();
    endtask

    // Restart arrives together with place and move pulses; restart must win.
    task automatic do_restart();
        @(negedge Clck);
        restart = 1'b1; btn_place = 1'b1; btn_right = 1'b1;
        @(negedge Clck);
        restart = 1'b0; btn_place = 1'b0; btn_right = 1'b0;
        model_reset();
        check_reset_vals("restart");
    endtask

    task automatic random_game(input int steps);
        for (int i = 0; i < steps; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                do_move($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end else begin
                do_place();
            end
        end
    endtask

    initial begin
        int p1x[$], p1y[$], p2x[$], p2y[$];
        Reset = 1'b1;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_place = 1'b0; restart = 1'b0;
        model_reset();
        repeat (3) @(negedge Clck);
        check_reset_vals("reset_held");
        Reset = 1'b0;
        @(negedge Clck);
        check_state("reset");

        // Cursor movement and clamping.
        repeat (3) do_move(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) do_move(1'b0, 1'b1, 1'b0, 1'b0);
        check("cursor_7", pointer_loc_x, 4'd7);
        check("cursor_8", pointer_loc_y, 4'd8);
        repeat (10) do_move(1'b0, 1'b0, 1'b1, 1'b0);
        check("clamp_left", pointer_loc_x, 4'd0);
        repeat (10) do_move(1'b1, 1'b0, 1'b0, 1'b0);
        check("clamp_up", pointer_loc_y, 4'd0);
        do_move(1'b1, 1'b1, 1'b1, 1'b1);
        do_move(1'b0, 1'b1, 1'b1, 1'b1);

        // First stone and occupied-cell rejection.
        place_at(4, 6);
        check("cell_4_6", board[200 +: 2], 2'b01);
        check("turn_p2", cur_player, 2'b10);
        do_place();

        // Horizontal five completed in the middle of the run.
        do_restart();
        place_at(0, 0); place_at(0, 1); place_at(1, 0); place_at(1, 1);
        place_at(3, 0); place_at(2, 1); place_at(4, 0); place_at(3, 1);
        place_at(2, 0);
        check("h_win_status", gaming_status, 2'b01);
        check("h_win_player", cur_player, 2'b01);
        do_place();
        do_move(1'b0, 1'b1, 1'b0, 1'b1);

        // Anti-diagonal win for player 2.
        do_restart();
        place_at(0, 0); place_at(10, 4); place_at(2, 0); place_at(9, 5);
        place_at(4, 0); place_at(7, 7); place_at(6, 0); place_at(6, 8);
        place_at(8, 0); place_at(8, 6);
        check("d3_win_status", gaming_status, 2'b10);

        // Edge cells: no wrap-around matches, then a win touching two edges.
        do_restart();
        place_at(13, 2); place_at(0, 8);  place_at(14, 2); place_at(2, 8);
        place_at(15, 2); place_at(4, 8);  place_at(0, 2);  place_at(6, 8);
        place_at(1, 2);  place_at(8, 8);
        check("wrap_no_win", gaming_status, 2'b00);
        place_at(0, 15); place_at(10, 8); place_at(1, 14); place_at(12, 8);
        place_at(2, 13); place_at(14, 8); place_at(3, 12); place_at(0, 10);
        place_at(4, 11);
        check("edge_win_status", gaming_status, 2'b01);

        // Randomized play against the model.
        for (int g = 0; g < 3; g++) begin
            do_restart();
            random_game(250);
        end

        // Full board with no five anywhere: draw on the final scan.
        do_restart();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if ((((x >> 1) + y) & 1) == 0) begin p1x.push_back(x); p1y.push_back(y); end
                else                            begin p2x.push_back(x); p2y.push_back(y); end
        for (int i = 0; i < 128; i++) begin
            place_at(p1x[i], p1y[i]);
            place_at(p2x[i], p2y[i]);
        end
        check("draw_status", gaming_status, 2'b11);
        do_place();
        do_restart();

        // Asynchronous reset in the middle of a scan.
        goto(9, 9);
        @(negedge Clck);
        btn_place = 1'b1;
        @(negedge Clck);
        btn_place = 1'b0;
        check("midscan_busy", busy, 1'b1);
        @(negedge Clck);
        #2 Reset = 1'b1;
        #1 check_reset_vals("async_reset");
        @(negedge Clck);
        Reset = 1'b0;
        model_reset();
        @(negedge Clck);
        check_state("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
